// File: rtl/store_check_responder.sv
// rtl/store_check_responder.sv - store-bus responder that logs stores and decides pass/fail/timeout
//
// Purpose: sits on the core's store interface. Every store made while running is
// logged in a first-word-fall-through FIFO, and the test outcome is decided in
// hardware from the store stream.
//
// Optional feature: define STORECHK_TIMEOUT_EN to build the RUN-state timeout
// (fail_code 3). When it is undefined the block waits indefinitely for a deciding store.
//
// Ports:
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   MemWrite, DataAdr, WriteData store strobe, byte address and data from the core
//   done, pass, fail             registered outcome flags
//   fail_code                    0 none, 1 bad address, 2 bad pass data, 3 timeout
//   fail_adr, fail_data          the store that caused the fail (0 on timeout)
//   cycle_count                  cycles spent in RUN, saturating, frozen once decided
//   log_rd_en                    pop the log head
//   log_valid, log_adr, log_data log head (first-word-fall-through)
//   log_overflow                 sticky, a store was dropped because the log was full
module store_check_responder #(
    parameter logic [31:0] PASS_ADDR      = 32'd100,
    parameter logic [31:0] PASS_DATA      = 32'd25,
    parameter logic [31:0] ALLOW_ADDR     = 32'd96,
    parameter int          TIMEOUT_CYCLES = 200,
    parameter int          LOG_DEPTH      = 8,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [31:0]      fail_adr,
    output logic [31:0]      fail_data,
    output logic [CNT_W-1:0] cycle_count,
    input  logic             log_rd_en,
    output logic             log_valid,
    output logic [31:0]      log_adr,
    output logic [31:0]      log_data,
    output logic             log_overflow
);

    localparam int AW = $clog2(LOG_DEPTH);
    localparam logic [AW:0]      DEPTH_V  = (AW+1)'(LOG_DEPTH);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef STORECHK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

    state_t      state, state_nx;
    logic [1:0]  code_nx;
    logic [31:0] fadr_nx, fdata_nx;
    logic        timeout_hit;

    // With the feature disabled TO_EN is a constant 0 and the comparator folds away.
    assign timeout_hit = TO_EN && (cycle_count == TO_LIMIT);

    always_comb begin
        state_nx = state;
        code_nx  = fail_code;
        fadr_nx  = fail_adr;
        fdata_nx = fail_data;
        if (state == ST_RUN) begin
            if (MemWrite && DataAdr == PASS_ADDR) begin
                if (WriteData == PASS_DATA) begin
                    state_nx = ST_PASS;
                end else begin
                    state_nx = ST_FAIL;
                    code_nx  = 2'd2;
                    fadr_nx  = DataAdr;
                    fdata_nx = WriteData;
                end
            end else if (MemWrite && DataAdr != ALLOW_ADDR) begin
                state_nx = ST_FAIL;
                code_nx  = 2'd1;
                fadr_nx  = DataAdr;
                fdata_nx = WriteData;
            end else if (timeout_hit) begin
                // Reached only when no store decided this edge: stores beat the timeout.
                state_nx = ST_FAIL;
                code_nx  = 2'd3;
                fadr_nx  = 32'd0;
                fdata_nx = 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            fail_code   <= 2'd0;
            fail_adr    <= 32'd0;
            fail_data   <= 32'd0;
            cycle_count <= '0;
        end else begin
            state     <= state_nx;
            fail_code <= code_nx;
            fail_adr  <= fadr_nx;
            fail_data <= fdata_nx;
            // The deciding edge does not count, so a timeout freezes at TIMEOUT_CYCLES-1.
            if (state == ST_RUN && state_nx == ST_RUN && cycle_count != '1)
                cycle_count <= cycle_count + 1'b1;
        end
    end

    assign pass = (state == ST_PASS);
    assign fail = (state == ST_FAIL);
    assign done = pass | fail;

    // Store log
    logic [AW:0]  wp, rp;
    logic [63:0]  mem [LOG_DEPTH];
    logic         full, push, pop, push_ok;

    assign log_valid = (wp != rp);
    assign full      = ((wp - rp) == DEPTH_V);
    assign pop       = log_rd_en && log_valid;
    assign push      = MemWrite && (state == ST_RUN);
    // A pop on the same edge frees the slot, so a full log still accepts the push.
    assign push_ok   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wp           <= '0;
            rp           <= '0;
            log_overflow <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
            if (push && !push_ok) log_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp[AW-1:0]] <= {DataAdr, WriteData};
    end

    assign log_adr  = mem[rp[AW-1:0]][63:32];
    assign log_data = mem[rp[AW-1:0]][31:0];

endmodule

// File: tb/tb_store_check_responder.sv
// tb/tb_store_check_responder.sv - bench for store_check_responder
module tb_store_check_responder;

    localparam int TO = 200;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr, WriteData;
    logic        done, pass, fail;
    logic [1:0]  fail_code;
    logic [31:0] fail_adr, fail_data;
    logic [15:0] cycle_count;
    logic        log_rd_en, log_valid, log_overflow;
    logic [31:0] log_adr, log_data;

    store_check_responder dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .done(done), .pass(pass), .fail(fail),
        .fail_code(fail_code), .fail_adr(fail_adr), .fail_data(fail_data),
        .cycle_count(cycle_count), .log_rd_en(log_rd_en), .log_valid(log_valid),
        .log_adr(log_adr), .log_data(log_data), .log_overflow(log_overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: outcome 0 running, 1 passed, 2 failed; log is a plain queue.
    typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
    ent_t        mq[$];
    int          m_out;
    int          m_code;
    logic [31:0] m_adr, m_data;
    int          m_cnt;
    bit          m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit mw, input logic [31:0] a,
                              input logic [31:0] d, input bit rd);
        bit decided, pop_ok, was_full;
        int nxt;
        ent_t e;
        if (rst) begin
            m_out = 0; m_code = 0; m_adr = 0; m_data = 0; m_cnt = 0; m_ovf = 0;
            mq.delete();
            return;
        end
        pop_ok   = rd && (mq.size() > 0);
        was_full = (mq.size() == DEPTH);
        nxt      = m_out;
        decided  = 0;
        if (m_out == 0) begin
            if (mw && a == 32'd100) begin
                decided = 1;
                if (d == 32'd25) nxt = 1;
                else begin nxt = 2; m_code = 2; m_adr = a; m_data = d; end
            end else if (mw && a != 32'd96) begin
                decided = 1; nxt = 2; m_code = 1; m_adr = a; m_data = d;
            end
`ifdef STORECHK_TIMEOUT_EN
            if (!decided && m_cnt == TO - 1) begin
                nxt = 2; m_code = 3; m_adr = 0; m_data = 0;
            end
`endif
            if (nxt == 0 && m_cnt < 65535) m_cnt++;
        end
        if (pop_ok) void'(mq.pop_front());
        if (m_out == 0 && mw) begin
            if (was_full && !pop_ok) m_ovf = 1;
            else begin e.a = a; e.d = d; mq.push_back(e); end
        end
        m_out = nxt;
    endtask

    // Inputs are applied and outputs sampled at the negedge.
    task automatic step(input bit rst, input bit mw, input logic [31:0] a,
                        input logic [31:0] d, input bit rd);
        reset = rst; MemWrite = mw; DataAdr = a; WriteData = d; log_rd_en = rd;
        @(posedge clk);
        model_edge(rst, mw, a, d, rd);
        @(negedge clk);
        reset = 1'b0; MemWrite = 1'b0; log_rd_en = 1'b0;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".done"}, done, (m_out != 0));
        chk({tag, ".pass"}, pass, (m_out == 1));
        chk({tag, ".fail"}, fail, (m_out == 2));
        chk({tag, ".code"}, fail_code, m_code);
        chk({tag, ".fadr"}, fail_adr, m_adr);
        chk({tag, ".fdata"}, fail_data, m_data);
        chk({tag, ".cnt"}, cycle_count, m_cnt);
        chk({tag, ".valid"}, log_valid, (mq.size() > 0));
        chk({tag, ".ovf"}, log_overflow, m_ovf);
        if (mq.size() > 0) begin
            chk({tag, ".ladr"}, log_adr, mq[0].a);
            chk({tag, ".ldata"}, log_data, mq[0].d);
        end
    endtask

    typedef struct {
        logic        mw;
        logic [31:0] adr;
        logic [31:0] data;
        logic        rd;
        logic        ep;
        logic        ef;
        logic [1:0]  ec;
        logic        ev;
        logic [31:0] ea;
        logic [31:0] ed;
    } vec_t;
    vec_t tbl[6];

    initial begin
        reset = 1'b1; MemWrite = 1'b0; DataAdr = 0; WriteData = 0; log_rd_en = 1'b0;
        tbl[0] = '{1'b1, 32'd96,  32'd7,  1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd96,  32'd7};
        tbl[1] = '{1'b1, 32'd100, 32'd25, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'd96,  32'd7};
        tbl[2] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'd100, 32'd25};
        tbl[3] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'd0,   32'd0};
        tbl[4] = '{1'b1, 32'd104, 32'd5,  1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'd0,   32'd0};
        tbl[5] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'd0,   32'd0};
        @(negedge clk);

        // Reset state
        do_reset();
        chk("rst.done", done, 0); chk("rst.pass", pass, 0); chk("rst.fail", fail, 0);
        chk("rst.code", fail_code, 0); chk("rst.fadr", fail_adr, 0); chk("rst.fdata", fail_data, 0);
        chk("rst.cnt", cycle_count, 0); chk("rst.valid", log_valid, 0); chk("rst.ovf", log_overflow, 0);

        // Table: pass sequence, log drain, stores ignored after PASS
        for (int i = 0; i < 6; i++) begin
            step(1'b0, tbl[i].mw, tbl[i].adr, tbl[i].data, tbl[i].rd);
            chk($sformatf("tbl%0d.pass", i), pass, tbl[i].ep);
            chk($sformatf("tbl%0d.fail", i), fail, tbl[i].ef);
            chk($sformatf("tbl%0d.done", i), done, tbl[i].ep | tbl[i].ef);
            chk($sformatf("tbl%0d.code", i), fail_code, tbl[i].ec);
            chk($sformatf("tbl%0d.valid", i), log_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d.ladr", i), log_adr, tbl[i].ea);
                chk($sformatf("tbl%0d.ldata", i), log_data, tbl[i].ed);
            end
        end

        // Bad address, later pass store ignored
        do_reset();
        step(1'b0, 1'b1, 32'd104, 32'd5, 1'b0);
        chk("badadr.fail", fail, 1); chk("badadr.code", fail_code, 1);
        chk("badadr.fadr", fail_adr, 104); chk("badadr.fdata", fail_data, 5);
        step(1'b0, 1'b1, 32'd100, 32'd25, 1'b0);
        chk("badadr.pass_after", pass, 0); chk("badadr.fail_after", fail, 1);
        chk("badadr.cnt_frozen", cycle_count, 0);

        // Bad pass data
        do_reset();
        step(1'b0, 1'b1, 32'd100, 32'd24, 1'b0);
        chk("baddata.fail", fail, 1); chk("baddata.code", fail_code, 2);
        chk("baddata.fadr", fail_adr, 100); chk("baddata.fdata", fail_data, 24);

        // Timeout
        do_reset();
        idle(TO - 1);
        chk("to.pre_done", done, 0); chk("to.pre_cnt", cycle_count, TO - 1);
        idle(1);
`ifdef STORECHK_TIMEOUT_EN
        chk("to.fail", fail, 1); chk("to.code", fail_code, 3);
        chk("to.fadr", fail_adr, 0); chk("to.cnt", cycle_count, TO - 1);
        idle(5);
        chk("to.cnt_frozen", cycle_count, TO - 1);
`else
        chk("noto.done", done, 0); chk("noto.cnt", cycle_count, TO);
        idle(5);
        chk("noto.cnt_runs", cycle_count, TO + 5); chk("noto.code", fail_code, 0);
`endif

        // Pass store on exactly the timeout edge wins
        do_reset();
        idle(TO - 1);
        step(1'b0, 1'b1, 32'd100, 32'd25, 1'b0);
        chk("to_edge.pass", pass, 1); chk("to_edge.fail", fail, 0);

        // Overflow: ten stores, eight kept
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'd96, i, 1'b0);
        chk("ovf.not_yet", log_overflow, 0);
        for (int i = 8; i < 10; i++) step(1'b0, 1'b1, 32'd96, i, 1'b0);
        chk("ovf.set", log_overflow, 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf.valid%0d", i), log_valid, 1);
            chk($sformatf("ovf.data%0d", i), log_data, i);
            step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        end
        chk("ovf.empty", log_valid, 0);

        // Push with pop while full: no drop
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'd96, i, 1'b0);
        step(1'b0, 1'b1, 32'd96, 32'd8, 1'b1);
        chk("fullpp.ovf", log_overflow, 0); chk("fullpp.head", log_data, 1);
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("fullpp.data%0d", i), log_data, i);
            step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        end
        chk("fullpp.empty", log_valid, 0);

        // Push with pop while empty: push only
        do_reset();
        step(1'b0, 1'b1, 32'd96, 32'd9, 1'b1);
        chk("emptypp.valid", log_valid, 1); chk("emptypp.data", log_data, 9);

        // Reset out of FAIL, then pass
        do_reset();
        step(1'b0, 1'b1, 32'd104, 32'd5, 1'b0);
        chk("rf.fail", fail, 1);
        do_reset();
        chk("rf.done", done, 0); chk("rf.fail0", fail, 0); chk("rf.code", fail_code, 0);
        chk("rf.fadr", fail_adr, 0); chk("rf.fdata", fail_data, 0); chk("rf.valid", log_valid, 0);
        step(1'b0, 1'b1, 32'd100, 32'd25, 1'b0);
        chk("rf.pass", pass, 1);

        // Randomized against the model
        for (int r = 0; r < 10; r++) begin
            do_reset();
            check_model("rnd_rst");
            for (int c = 0; c < 300; c++) begin
                bit mw, rd;
                logic [31:0] a, d;
                int sel;
                mw  = ($urandom_range(0, 2) == 0);
                rd  = ($urandom_range(0, 3) == 0);
                sel = $urandom_range(0, 199);
                a   = (sel == 0) ? 32'd100 : (sel == 1) ? $urandom : 32'd96;
                d   = ($urandom_range(0, 1) == 0) ? 32'd25 : $urandom;
                step(1'b0, mw, a, d, rd);
                check_model("rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/store_check_responder.md
Name: store_check_responder

Overview:
- Synthesizable memory-side responder on the core's store interface (clk, reset, MemWrite, DataAdr, WriteData); the consumer end of the store bus out of the pipelined top.
- Samples every store and logs it in a small FIFO.
- Decides pass/fail/timeout in hardware so FPGA and silicon runs can self-check without a simulator bench.

Parameters:
- PASS_ADDR, 100, store address that terminates the test.
- PASS_DATA, 25, data required at PASS_ADDR for a pass.
- ALLOW_ADDR, 96, one additional address stores may target without failing.
- TIMEOUT_CYCLES, 200, cycles in RUN before timeout fail; legal range 1..2^CNT_W-1.
- LOG_DEPTH, 8, store-log FIFO depth; power of two, >=2.
- CNT_W, 16, cycle counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- MemWrite  in  1  store strobe from core
- DataAdr  in  32  store byte address
- WriteData  in  32  store data
- done  out  1  test finished (pass or fail)
- pass  out  1  finished with pass
- fail  out  1  finished with fail
- fail_code  out  2  0 none, 1 bad address, 2 bad pass data, 3 timeout
- fail_adr  out  32  address of the failing store
- fail_data  out  32  data of the failing store
- cycle_count  out  CNT_W  cycles spent in RUN
- log_rd_en  in  1  pop the log head
- log_valid  out  1  log non-empty
- log_adr  out  32  head entry address, first-word-fall-through
- log_data  out  32  head entry data
- log_overflow  out  1  sticky: a store was dropped because the log was full

Behaviour:
- Reset (sampled at posedge):
  - state=RUN.
  - done, pass, fail, fail_code, fail_adr, fail_data, cycle_count, log_overflow all 0.
  - FIFO emptied; log_valid=0.
  - A reset asserted mid-test, including in PASS or FAIL, fully reinitializes the block on that edge.
- States: RUN, PASS, FAIL. PASS and FAIL are absorbing until reset.
- In RUN, at each posedge with MemWrite=1, evaluate in this priority order:
  - DataAdr==PASS_ADDR and WriteData==PASS_DATA: go to PASS.
  - DataAdr==PASS_ADDR with other data: go to FAIL, fail_code=2.
  - DataAdr!=ALLOW_ADDR: go to FAIL, fail_code=1.
  - DataAdr==ALLOW_ADDR: stay in RUN.
- On entering FAIL on a store, fail_adr/fail_data capture that store's DataAdr/WriteData.
- Outputs are registered. pass/fail/done are valid the cycle after the deciding edge (1-cycle latency).
- cycle_count:
  - Increments every cycle in RUN and saturates at all-ones.
  - Frozen in PASS and FAIL.
- Timeout: in RUN with no deciding store that cycle, when cycle_count==TIMEOUT_CYCLES-1, go to FAIL with fail_code=3, fail_adr=0, fail_data=0.
- Store vs timeout on the same edge: the store decision wins.
- Log FIFO:
  - Pushes {DataAdr, WriteData} on every MemWrite edge in RUN, including the deciding store.
  - Stores arriving in PASS or FAIL are ignored, not logged.
  - Pop occurs when log_rd_en && log_valid; pop on empty is ignored.
  - Push while full without a simultaneous pop: entry dropped and log_overflow set.
  - Push and pop on the same edge while full: both performed, no drop.
  - Push and pop on the same edge while empty: the entry is pushed only; the head becomes visible the next cycle.
  - Read and write pointers are log2(LOG_DEPTH)+1 bits and wrap naturally.
  - The log stays readable in PASS and FAIL.
- Address comparison is full 32-bit equality.
- MemWrite with X/Z inputs is out of scope.

Optional Feature:
- Macro STORECHK_TIMEOUT_EN.
- Defined: the timeout check above is built in, so fail_code=3 is reachable.
- Undefined:
  - No timeout comparator is built; the block stays in RUN indefinitely absent a deciding store.
  - cycle_count still counts and saturates.
  - fail_code never equals 3.

Test Plan:
- Store (96,7), then (100,25) -> next cycle pass=1, done=1, fail=0; log pops (96,7) then (100,25); log_valid=0 afterwards.
- Store (104,5) -> fail=1, fail_code=1, fail_adr=104, fail_data=5; a later store (100,25) is ignored and pass stays 0.
- Store (100,24) -> fail=1, fail_code=2, fail_data=24.
- With STORECHK_TIMEOUT_EN defined, no stores for 200 cycles -> fail_code=3, cycle_count=199 frozen.
  - A store (100,25) on exactly the timeout edge -> pass=1 instead.
- Ten stores to 96 with no reads (LOG_DEPTH=8) -> log_overflow=1 and 8 entries readable.
  - Push with simultaneous pop when full -> no overflow.
- Reach FAIL, assert reset for 1 cycle -> all outputs 0 and state RUN.
  - Then (100,25) -> pass=1.
